// File: rtl/adder_arb_pkg.sv
// Shared definitions for the shared-adder arbiter.
// Holds the FSM state encoding and a one-hot helper used to build the ack vector.
package adder_arb_pkg;

  // Upper bound on requesters; onehot() returns this many bits and callers slice.
  localparam int unsigned MAX_REQ = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_DRIVE   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req_i   - eligible request vector
//   ptr_i   - last served index; search starts at ptr_i+1 and wraps
//   found_o - at least one request is eligible
//   idx_o   - index of the first eligible request after ptr_i
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]          req_i,
  input  logic [$clog2(NREQ)-1:0]  ptr_i,
  output logic                     found_o,
  output logic [$clog2(NREQ)-1:0]  idx_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [IdxW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_bus_arbiter.sv
// Round-robin arbiter sharing one tri-state adder among NREQ requesters.
// A granted requester's operands are latched, driven with add_en high for SETTLE+1
// cycles, and the adder bus is sampled in the last of those cycles; the result is
// returned with a one-cycle one-hot ack.
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   req             - request levels, held until the matching ack
//   a_flat, b_flat  - packed operands, requester i at [i*W +: W]
//   ack, sum        - one-hot result strobe and captured sum (held between acks)
//   gnt_id, busy    - current/last grant index; operation in flight
//   add_a, add_b    - adder operands (zero when idle)
//   add_en          - adder enable (this block is its only driver)
//   add_c           - adder result bus, undriven while add_en is low
module adder_bus_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned W      = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       a_flat,
  input  logic [NREQ*W-1:0]       b_flat,
  output logic [NREQ-1:0]         ack,
  output logic [W-1:0]            sum,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  output logic                    add_en,
  input  logic [W-1:0]            add_c
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      op_a_q, op_a_d;
  logic [W-1:0]      op_b_q, op_b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [MAX_REQ-1:0] gnt_oh;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;

  // A requester being acked this cycle may still show req; mask it so a late drop
  // does not earn it a second grant.
  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i   (req & ~ack_q),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    ack_d   = '0;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    gnt_oh  = onehot(3'(gnt_q));
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          op_a_d  = a_flat[32'(pick_idx) * W +: W];
          op_b_d  = b_flat[32'(pick_idx) * W +: W];
          gnt_d   = pick_idx;
          cnt_d   = CntW'(SETTLE - 1);
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        // add_en is still high here, so add_c is a driven value.
        sum_d   = add_c;
        ack_d   = gnt_oh[NREQ-1:0];
        ptr_d   = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= IdxW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    add_en = (state_q != ST_IDLE);
    busy   = add_en;
    add_a  = add_en ? op_a_q : '0;
    add_b  = add_en ? op_b_q : '0;
    ack    = ack_q;
    sum    = sum_q;
    gnt_id = gnt_q;
  end

endmodule

// File: tb/tb_adder_bus_arbiter.sv
// Self-checking bench for adder_bus_arbiter (NREQ=4, W=4, SETTLE=1).
// Directed scenarios followed by a randomized phase, all cross-checked against a
// transaction-level model that tracks the grant timeline in cycles.
module tb_adder_bus_arbiter;

  localparam int NREQ   = 4;
  localparam int W      = 4;
  localparam int SETTLE = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*W-1:0]       a_flat;
  logic [NREQ*W-1:0]       b_flat;
  logic [NREQ-1:0]         ack;
  logic [W-1:0]            sum;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                    busy;
  logic [W-1:0]            add_a;
  logic [W-1:0]            add_b;
  logic                    add_en;
  logic [W-1:0]            add_c;
  logic [W-1:0]            idle_val;

  always #5 clk = ~clk;

  // Behavioural adder: drives the sum while enabled, otherwise an idle/floating value.
  assign add_c = add_en ? (add_a + add_b) : idle_val;

  adder_bus_arbiter #(
    .NREQ   (NREQ),
    .W      (W),
    .SETTLE (SETTLE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .ack    (ack),
    .sum    (sum),
    .gnt_id (gnt_id),
    .busy   (busy),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_en (add_en),
    .add_c  (add_c)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: an operation occupies the adder for SETTLE+1 enabled cycles,
  // then its ack appears for one cycle.
  int m_active, m_left, m_owner, m_ptr, m_ack, m_gnt, m_a, m_b, m_sum;

  task automatic model_edge();
    int new_ack;
    int c;
    new_ack = -1;
    if (rst) begin
      m_active = 0; m_left = 0; m_owner = 0; m_ptr = NREQ - 1;
      m_ack = -1; m_gnt = 0; m_a = 0; m_b = 0; m_sum = 0;
    end else begin
      if (m_active != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_sum    = (m_a + m_b) % (1 << W);
          new_ack  = m_owner;
          m_ptr    = m_owner;
          m_active = 0;
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (m_active == 0 && req[c] && c != m_ack) begin
            m_active = 1;
            m_left   = SETTLE + 1;
            m_owner  = c;
            m_gnt    = c;
            m_a      = int'(a_flat[c*W +: W]);
            m_b      = int'(b_flat[c*W +: W]);
          end
        end
      end
      m_ack = new_ack;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("m_add_en", 32'(add_en), 32'(m_active));
    check("m_busy",   32'(busy),   32'(m_active));
    check("m_ack",    32'(ack),    (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
    check("m_sum",    32'(sum),    32'(m_sum));
    check("m_gnt_id", 32'(gnt_id), 32'(m_gnt));
    check("m_add_a",  32'(add_a),  (m_active != 0) ? 32'(m_a) : 32'd0);
    check("m_add_b",  32'(add_b),  (m_active != 0) ? 32'(m_b) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  logic [3:0] fair_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] fair_sum [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
  bit         late [NREQ];

  initial begin
    rst = 1'b1; req = '0; a_flat = '0; b_flat = '0; idle_val = 4'bz;
    for (int i = 0; i < NREQ; i++) late[i] = 1'b0;
    step();
    step();
    check("rst_ack",    32'(ack),    32'd0);
    check("rst_sum",    32'(sum),    32'd0);
    check("rst_gnt",    32'(gnt_id), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_add_a",  32'(add_a),  32'd0);
    rst = 1'b0;

    // Single request from requester 0.
    a_flat[3:0] = 4'd3; b_flat[3:0] = 4'd4; req = 4'b0001;
    step();
    check("single_c1_en", 32'(add_en), 32'd1);
    check("single_c1_a",  32'(add_a),  32'd3);
    check("single_c1_b",  32'(add_b),  32'd4);
    step();
    check("single_c2_en", 32'(add_en), 32'd1);
    step();
    check("single_c3_ack", 32'(ack),    32'b0001);
    check("single_c3_sum", 32'(sum),    32'd7);
    check("single_c3_en",  32'(add_en), 32'd0);
    req = '0;
    step();

    // Carry-out discarded.
    a_flat[11:8] = 4'hF; b_flat[11:8] = 4'h2; req = 4'b0100;
    step(); step(); step();
    check("ovf_ack", 32'(ack),    32'b0100);
    check("ovf_sum", 32'(sum),    32'd1);
    check("ovf_gnt", 32'(gnt_id), 32'd2);
    req = '0;
    step();

    // Fairness with all requesters held.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_flat[i*W +: W] = W'(i);
      b_flat[i*W +: W] = 4'hA;
    end
    req = 4'b1111;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      step();
      if (cyc % 3 == 0) begin
        check("fair_ack", 32'(ack), 32'(fair_ack[cyc/3 - 1]));
        check("fair_sum", 32'(sum), 32'(fair_sum[cyc/3 - 1]));
      end
    end
    req = '0;
    rst = 1'b1; step(); rst = 1'b0;

    // Late drop by requester 1, requester 3 waiting.
    a_flat[7:4] = 4'd5; b_flat[7:4] = 4'd6; req = 4'b0010;
    step();
    a_flat[15:12] = 4'd7; b_flat[15:12] = 4'd1; req[3] = 1'b1;
    step();
    step();
    check("late_ack1", 32'(ack), 32'b0010);
    check("late_sum1", 32'(sum), 32'hB);
    step();
    check("late_gnt3", 32'(gnt_id), 32'd3);
    check("late_en3",  32'(add_en), 32'd1);
    req[1] = 1'b0;
    step();
    step();
    check("late_ack3", 32'(ack), 32'b1000);
    check("late_sum3", 32'(sum), 32'd8);
    req[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("late_no_regrant", 32'({busy, ack}), 32'd0);
    end

    // Reset while driving the adder.
    req = 4'b0010;
    step();
    check("rdrv_c1_en", 32'(add_en), 32'd1);
    rst = 1'b1;
    step();
    check("rdrv_en",   32'(add_en), 32'd0);
    check("rdrv_busy", 32'(busy),   32'd0);
    check("rdrv_ack",  32'(ack),    32'd0);
    rst = 1'b0; req = 4'b1111;
    step();
    check("rdrv_first_gnt", 32'(gnt_id), 32'd0);
    step();
    step();
    check("rdrv_ack0", 32'(ack), 32'b0001);
    check("rdrv_sum0", 32'(sum), 32'hA);
    req = '0;

    // Floating/unknown adder bus while idle must not leak into sum.
    idle_val = 4'bx;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_en",  32'(add_en), 32'd0);
      check("idle_ack", 32'(ack),    32'd0);
      check("idle_sum", 32'(sum),    32'hA);
    end
    idle_val = 4'bz;

    // Randomized traffic with late drops, operand churn and occasional resets.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (late[i]) begin
          req[i]  = 1'b0;
          late[i] = 1'b0;
        end else if (m_ack == i) begin
          if ($urandom_range(0, 2) == 0) late[i] = 1'b1;
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      a_flat = NREQ*W'($urandom);
      b_flat = NREQ*W'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
